// File: rtl/median_window_gen.sv
// Raster pixel stream -> 3x3 neighbourhood windows for the median sorter.
// Two column-indexed line buffers feed the top/middle rows of a shifting 3x3 window.
module median_window_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pixIn,
  input  logic              pixValid,
  input  logic              sof,
  output logic [DATA_W-1:0] dataOut0,
  output logic [DATA_W-1:0] dataOut1,
  output logic [DATA_W-1:0] dataOut2,
  output logic [DATA_W-1:0] dataOut3,
  output logic [DATA_W-1:0] dataOut4,
  output logic [DATA_W-1:0] dataOut5,
  output logic [DATA_W-1:0] dataOut6,
  output logic [DATA_W-1:0] dataOut7,
  output logic [DATA_W-1:0] dataOut8,
  output logic              winValid,
  output logic              frameDone
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0]                r_col;
  logic [RW-1:0]                r_row;
  logic [8:0][DATA_W-1:0]       r_win;
  logic                         r_win_vld;
  logic                         r_frame_done;
  logic [DATA_W-1:0]            r_lb1 [IMG_W];
  logic [DATA_W-1:0]            r_lb2 [IMG_W];

  logic [CW-1:0]     w_col;
  logic [RW-1:0]     w_row;
  logic [DATA_W-1:0] w_lb1;
  logic [DATA_W-1:0] w_lb2;
  logic              w_eol;
  logic              w_eof;

  // sof forces the current pixel to (0,0) whatever the counters say
  assign w_col = sof ? '0 : r_col;
  assign w_row = sof ? '0 : r_row;
  assign w_lb1 = r_lb1[w_col];
  assign w_lb2 = r_lb2[w_col];
  assign w_eol = (w_col == CW'(IMG_W - 1));
  assign w_eof = w_eol && (w_row == RW'(IMG_H - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_win        <= '0;
      r_win_vld    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_win_vld    <= 1'b0;
      r_frame_done <= 1'b0;
      if (pixValid) begin
        r_win_vld    <= (w_row >= RW'(2)) && (w_col >= CW'(2));
        r_frame_done <= w_eof;
        for (int r = 0; r < 3; r++) begin
          r_win[3*r]   <= r_win[3*r+1];
          r_win[3*r+1] <= r_win[3*r+2];
        end
        r_win[2] <= w_lb2;
        r_win[5] <= w_lb1;
        r_win[8] <= pixIn;
        if (w_eof) begin
          r_col <= '0;
          r_row <= '0;
        end else if (w_eol) begin
          r_col <= '0;
          r_row <= w_row + RW'(1);
        end else begin
          r_col <= w_col + CW'(1);
          r_row <= w_row;
        end
      end
    end
  end

  // Line buffers are never cleared: rows 0/1 of each frame refill them before use
  always_ff @(posedge clk) begin
    if (rst && pixValid) begin
      r_lb2[w_col] <= w_lb1;
      r_lb1[w_col] <= pixIn;
    end
  end

  assign dataOut0  = r_win[0];
  assign dataOut1  = r_win[1];
  assign dataOut2  = r_win[2];
  assign dataOut3  = r_win[3];
  assign dataOut4  = r_win[4];
  assign dataOut5  = r_win[5];
  assign dataOut6  = r_win[6];
  assign dataOut7  = r_win[7];
  assign dataOut8  = r_win[8];
  assign winValid  = r_win_vld;
  assign frameDone = r_frame_done;
endmodule

// File: tb/tb_median_window_gen.sv
// Bench for median_window_gen: frame-image model predicts every window, compared each cycle.
module tb_median_window_gen;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] pixIn = '0;
  logic          pixValid = 1'b0;
  logic          sof = 1'b0;
  logic [DW-1:0] d0, d1, d2, d3, d4, d5, d6, d7, d8;
  logic          winValid, frameDone;

  median_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .pixIn(pixIn), .pixValid(pixValid), .sof(sof),
    .dataOut0(d0), .dataOut1(d1), .dataOut2(d2), .dataOut3(d3), .dataOut4(d4),
    .dataOut5(d5), .dataOut6(d6), .dataOut7(d7), .dataOut8(d8),
    .winValid(winValid), .frameDone(frameDone)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wv_cnt = 0;
  int fd_cnt = 0;

  // Model: the frame as a 2D image; a window is the 3x3 block ending at the accepted pixel
  logic [DW-1:0] img [H][W];
  int  mrow = 0, mcol = 0;
  bit  exp_wv = 1'b0, exp_fd = 1'b0;
  logic [9*DW-1:0] exp_win = '0;
  logic [9*DW-1:0] mq [$];

  function automatic logic [9*DW-1:0] w9(input int a, b, c, d, e, f, g, h, i);
    return {DW'(a), DW'(b), DW'(c), DW'(d), DW'(e), DW'(f), DW'(g), DW'(h), DW'(i)};
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      mrow = 0; mcol = 0; exp_wv = 1'b0; exp_fd = 1'b0;
    end else begin
      exp_wv = 1'b0; exp_fd = 1'b0;
      if (pixValid) begin
        if (sof) begin mrow = 0; mcol = 0; end
        img[mrow][mcol] = pixIn;
        if (mrow >= 2 && mcol >= 2) begin
          exp_wv = 1'b1;
          for (int k = 0; k < 9; k++)
            exp_win[(8-k)*DW +: DW] = img[mrow-2+k/3][mcol-2+k%3];
          mq.push_back(exp_win);
        end
        exp_fd = (mrow == H-1) && (mcol == W-1);
        mcol++;
        if (mcol == W) begin
          mcol = 0; mrow++;
          if (mrow == H) mrow = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Every-cycle comparison against the model
  always begin
    @(posedge clk); #2;
    if (winValid === 1'b1) wv_cnt++;
    if (frameDone === 1'b1) fd_cnt++;
    chk("winValid", 72'(winValid), 72'(exp_wv));
    chk("frameDone", 72'(frameDone), 72'(exp_fd));
    if (exp_wv && winValid === 1'b1)
      chk("window", {d0, d1, d2, d3, d4, d5, d6, d7, d8}, exp_win);
  end

  task automatic px(input int p, input bit s);
    @(negedge clk);
    pixIn = DW'(p); pixValid = 1'b1; sof = s;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pixValid = 1'b0; sof = 1'b0; pixIn = DW'($urandom);
    end
  endtask

  task automatic ramp(input int base, input bit with_sof, input bit gapped);
    for (int i = 0; i < W*H; i++) begin
      px(base + i, with_sof && i == 0);
      if (gapped) idle(1);
    end
  endtask

  task automatic start(string nm);
    idle(3);
    wv_cnt = 0; fd_cnt = 0; mq.delete();
  endtask

  task automatic finish_test(input string nm, input int nwin, input int nfd);
    idle(4);
    chk({nm, " windows"}, 72'(wv_cnt), 72'(nwin));
    chk({nm, " frameDone"}, 72'(fd_cnt), 72'(nfd));
    chk({nm, " model windows"}, 72'(mq.size()), 72'(nwin));
  endtask

  initial begin
    // 1 reset
    repeat (5) @(posedge clk);
    #2;
    chk("reset winValid", 72'(winValid), 72'(0));
    chk("reset frameDone", 72'(frameDone), 72'(0));
    chk("reset data", {d0, d1, d2, d3, d4, d5, d6, d7, d8}, '0);
    @(negedge clk); rst = 1'b1;

    // 2 ramp frame
    start("ramp");
    ramp(0, 1'b1, 1'b0);
    finish_test("ramp", 4, 1);
    if (mq.size() == 4) begin
      chk("ramp first model", mq[0], w9(0, 1, 2, 4, 5, 6, 8, 9, 10));
      chk("ramp last model", mq[3], w9(5, 6, 7, 9, 10, 11, 13, 14, 15));
    end

    // 3 gapped input
    start("gap");
    ramp(0, 1'b1, 1'b1);
    finish_test("gap", 4, 1);
    if (mq.size() == 4) chk("gap first model", mq[0], w9(0, 1, 2, 4, 5, 6, 8, 9, 10));

    // 4 back-to-back frames, second relies on counter wrap
    start("b2b");
    ramp(0, 1'b1, 1'b0);
    ramp(16, 1'b0, 1'b0);
    finish_test("b2b", 8, 2);
    if (mq.size() == 8) chk("b2b frame2 first model", mq[4], w9(16, 17, 18, 20, 21, 22, 24, 25, 26));

    // 5 mid-frame sof
    start("midsof");
    for (int i = 0; i < 7; i++) px(50 + i, i == 0);
    ramp(100, 1'b1, 1'b0);
    finish_test("midsof", 4, 1);
    if (mq.size() == 4) chk("midsof first model", mq[0], w9(100, 101, 102, 104, 105, 106, 108, 109, 110));

    // 6 reset mid-frame, then frame without sof
    start("midrst");
    for (int i = 0; i < 9; i++) px(200 + i, i == 0);
    @(negedge clk); pixValid = 1'b0; rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ramp(0, 1'b0, 1'b0);
    finish_test("midrst", 4, 1);
    if (mq.size() == 4) chk("midrst last model", mq[3], w9(5, 6, 7, 9, 10, 11, 13, 14, 15));

    // random pixels with random gaps
    start("rand");
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < W*H; i++) begin
        px($urandom_range(0, 255), f == 0 && i == 0);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
    finish_test("rand", 12, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
